// File: rtl/ssd_scan_ctrl_if.sv
// Bus between score/status logic (master) and the seven-segment scan controller (slave).
// Carries the digit snapshot request, display controls and the multiplexed pin outputs.
interface ssd_scan_ctrl_if #(
  parameter int N_DIGITS = 4,
  parameter int BW       = 3
);
  logic                    enable;
  logic [4*N_DIGITS-1:0]   digits;
  logic [N_DIGITS-1:0]     dp_in;
  logic                    blank_lz;
  logic [BW-1:0]           brightness;
  logic [7:0]              SSD;
  logic [N_DIGITS-1:0]     SSD_sel;
  logic                    scan_tick;

  modport master (
    output enable, digits, dp_in, blank_lz, brightness,
    input  SSD, SSD_sel, scan_tick
  );

  modport slave (
    input  enable, digits, dp_in, blank_lz, brightness,
    output SSD, SSD_sel, scan_tick
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment driver: snapshots a hex digit bus and scans it out
// with per-digit decimal points, leading-zero blanking and PWM brightness. Outputs registered.
module ssd_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int DIV_LOG2 = 16,
  parameter int BW       = 3
) (
  input  logic           clk,
  input  logic           rst,
  ssd_scan_ctrl_if.slave bus
);
  localparam int                  IW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DIV_LOG2-1:0] PRESC_MAX = '1;
  localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);

  logic [DIV_LOG2-1:0]   presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [7:0]            ssd_q, ssd_d;
  logic [N_DIGITS-1:0]   sel_q, sel_d;
  logic                  tick_q, tick_d;

  logic [6:0]            seg_w [N_DIGITS];
  logic [N_DIGITS-1:0]   blank_w;
  logic [BW-1:0]         top_w;
  logic                  lit_w;
  logic                  wrap_w;
  logic                  seen_nz;

  function automatic logic [6:0] seg7(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_dec
    assign seg_w[gi] = seg7(digits_q[4*gi +: 4]);
  end

  // Walk from the most significant digit down; digit 0 is always shown.
  always_comb begin
    blank_w = '0;
    seen_nz = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      seen_nz    = seen_nz | (|digits_q[4*i +: 4]);
      blank_w[i] = bus.blank_lz & ~seen_nz;
    end
  end

  assign wrap_w = (presc_q == PRESC_MAX);
  assign top_w  = presc_q[DIV_LOG2-1 -: BW];
  assign lit_w  = (&bus.brightness) || (top_w < bus.brightness);

  always_comb begin
    presc_d  = presc_q + 1'b1;
    idx_d    = idx_q;
    if (wrap_w) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    digits_d = bus.enable ? bus.digits : digits_q;
    dp_d     = bus.enable ? bus.dp_in  : dp_q;
    tick_d   = wrap_w;

    ssd_d = 8'hFF;
    sel_d = '1;
    if (lit_w && !blank_w[idx_q]) begin
      ssd_d        = {~dp_q[idx_q], seg_w[idx_q]};
      sel_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      idx_q    <= '0;
      digits_q <= '0;
      dp_q     <= '0;
      ssd_q    <= 8'hFF;
      sel_q    <= '1;
      tick_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      ssd_q    <= ssd_d;
      sel_q    <= sel_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.SSD       = ssd_q;
  assign bus.SSD_sel   = sel_q;
  assign bus.scan_tick = tick_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Testbench for ssd_scan_ctrl (N_DIGITS=4, DIV_LOG2=4, BW=2): directed scenarios plus
// random traffic, compared against a cycle-count based model of the display.
module tb_ssd_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssd_scan_ctrl_if #(.N_DIGITS(4), .BW(2)) bus ();

  ssd_scan_ctrl #(.N_DIGITS(4), .DIV_LOG2(4), .BW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: n = clock edges since reset release; snapshot as seen by the display.
  int          n;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic [7:0]  exp_ssd;
  logic [3:0]  exp_sel;
  logic        exp_tick;
  logic [7:0]  seg_tab [16];

  task automatic model_reset();
    n        = 0;
    m_digits = 16'h0000;
    m_dp     = 4'h0;
  endtask

  // Advance one clock; expected outputs come from the state before the edge.
  task automatic step();
    int         p;
    int         id;
    logic [3:0] d;
    logic       lit;
    logic       blanked;
    @(posedge clk);
    n++;
    p       = (n - 1) % 16;
    id      = ((n - 1) / 16) % 4;
    d       = 4'((m_digits >> (4 * id)) & 16'h000F);
    blanked = bus.blank_lz && (id != 0) && ((m_digits >> (4 * id)) == 16'h0000);
    lit     = (bus.brightness == 2'd3) || ((p / 4) < int'(bus.brightness));
    if (lit && !blanked) begin
      exp_ssd = {~m_dp[id], seg_tab[d][6:0]};
      exp_sel = ~(4'b0001 << id);
    end else begin
      exp_ssd = 8'hFF;
      exp_sel = 4'hF;
    end
    exp_tick = (p == 15);
    if (bus.enable) begin
      m_digits = bus.digits;
      m_dp     = bus.dp_in;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.enable     = 1'($urandom);
      bus.digits     = 16'($urandom);
      bus.dp_in      = 4'($urandom);
      bus.blank_lz   = 1'($urandom);
      bus.brightness = 2'($urandom);
      @(negedge clk);
      checks++;
      if (bus.SSD !== 8'hFF || bus.SSD_sel !== 4'hF || bus.scan_tick !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold got SSD=%h sel=%h tick=%b want SSD=ff sel=f tick=0",
                 bus.SSD, bus.SSD_sel, bus.scan_tick);
      end
    end
    rst = 1'b1;
    model_reset();
    bus.brightness = 2'd3;
    bus.blank_lz   = 1'b0;
    for (int c = 0; c < 21; c++) begin
      step();
      checks++;
      if (bus.SSD !== exp_ssd || bus.SSD_sel !== exp_sel || bus.scan_tick !== exp_tick) begin
        failures++;
        $display("FAIL reset_release n=%0d got SSD=%h sel=%h tick=%b want SSD=%h sel=%h tick=%b",
                 n, bus.SSD, bus.SSD_sel, bus.scan_tick, exp_ssd, exp_sel, exp_tick);
      end
    end
    // Asynchronous assertion between clock edges.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.SSD !== 8'hFF || bus.SSD_sel !== 4'hF || bus.scan_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got SSD=%h sel=%h tick=%b want SSD=ff sel=f tick=0",
               bus.SSD, bus.SSD_sel, bus.scan_tick);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    bus.enable = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (bus.SSD !== exp_ssd || bus.SSD_sel !== exp_sel || bus.scan_tick !== exp_tick) begin
        failures++;
        $display("FAIL reset_restart n=%0d got SSD=%h sel=%h tick=%b want SSD=%h sel=%h tick=%b",
                 n, bus.SSD, bus.SSD_sel, bus.scan_tick, exp_ssd, exp_sel, exp_tick);
      end
    end
  endtask

  task automatic test_scan_order();
    int ticks;
    apply_reset();
    bus.digits = 16'h1234; bus.dp_in = 4'h0; bus.brightness = 2'd3; bus.blank_lz = 1'b0;
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    ticks = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (bus.scan_tick === 1'b1 && c < 64) ticks++;
      checks++;
      if (bus.SSD !== exp_ssd || bus.SSD_sel !== exp_sel || bus.scan_tick !== exp_tick) begin
        failures++;
        $display("FAIL scan_order n=%0d got SSD=%h sel=%h tick=%b want SSD=%h sel=%h tick=%b",
                 n, bus.SSD, bus.SSD_sel, bus.scan_tick, exp_ssd, exp_sel, exp_tick);
      end
    end
    checks++;
    if (ticks !== 4) begin
      failures++;
      $display("FAIL scan_tick_count got %0d want 4", ticks);
    end
  endtask

  task automatic test_hold();
    bus.digits = 16'hFFFF; bus.enable = 1'b0;
    for (int c = 0; c < 96; c++) begin
      if (c == 64) bus.enable = 1'b1;
      if (c == 65) bus.enable = 1'b0;
      step();
      checks++;
      if (bus.SSD !== exp_ssd || bus.SSD_sel !== exp_sel || bus.scan_tick !== exp_tick) begin
        failures++;
        $display("FAIL hold n=%0d got SSD=%h sel=%h tick=%b want SSD=%h sel=%h tick=%b",
                 n, bus.SSD, bus.SSD_sel, bus.scan_tick, exp_ssd, exp_sel, exp_tick);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] pat [3];
    logic        blk [3];
    pat[0] = 16'h0050; blk[0] = 1'b1;
    pat[1] = 16'h0000; blk[1] = 1'b1;
    pat[2] = 16'h0000; blk[2] = 1'b0;
    apply_reset();
    bus.brightness = 2'd3; bus.dp_in = 4'h0;
    for (int k = 0; k < 3; k++) begin
      bus.digits = pat[k]; bus.blank_lz = blk[k]; bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      for (int c = 0; c < 64; c++) begin
        step();
        checks++;
        if (bus.SSD !== exp_ssd || bus.SSD_sel !== exp_sel || bus.scan_tick !== exp_tick) begin
          failures++;
          $display("FAIL leading_zero pat=%h n=%0d got SSD=%h sel=%h tick=%b want SSD=%h sel=%h tick=%b",
                   pat[k], n, bus.SSD, bus.SSD_sel, bus.scan_tick, exp_ssd, exp_sel, exp_tick);
        end
      end
    end
  endtask

  task automatic test_dp();
    int seen_dp0;
    bus.digits = 16'h0008; bus.dp_in = 4'b0001; bus.brightness = 2'd3;
    seen_dp0 = 0;
    for (int k = 0; k < 2; k++) begin
      bus.blank_lz = 1'(k); bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      for (int c = 0; c < 64; c++) begin
        step();
        if (bus.SSD_sel === 4'hE && bus.SSD === 8'h00) seen_dp0++;
        checks++;
        if (bus.SSD !== exp_ssd || bus.SSD_sel !== exp_sel || bus.scan_tick !== exp_tick) begin
          failures++;
          $display("FAIL dp blank=%0d n=%0d got SSD=%h sel=%h tick=%b want SSD=%h sel=%h tick=%b",
                   k, n, bus.SSD, bus.SSD_sel, bus.scan_tick, exp_ssd, exp_sel, exp_tick);
        end
      end
    end
    checks++;
    if (seen_dp0 !== 32) begin
      failures++;
      $display("FAIL dp_digit0_cycles got %0d want 32", seen_dp0);
    end
  endtask

  task automatic test_pwm();
    int active;
    int want;
    bus.blank_lz = 1'b0; bus.digits = 16'h9A7C; bus.dp_in = 4'b1010; bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.brightness = 2'(b);
      step();
      active = 0;
      for (int c = 0; c < 64; c++) begin
        step();
        if (bus.SSD_sel !== 4'hF) active++;
        checks++;
        if (bus.SSD !== exp_ssd || bus.SSD_sel !== exp_sel || bus.scan_tick !== exp_tick) begin
          failures++;
          $display("FAIL pwm b=%0d n=%0d got SSD=%h sel=%h tick=%b want SSD=%h sel=%h tick=%b",
                   b, n, bus.SSD, bus.SSD_sel, bus.scan_tick, exp_ssd, exp_sel, exp_tick);
        end
      end
      want = (b == 3) ? 64 : 16 * b;
      checks++;
      if (active !== want) begin
        failures++;
        $display("FAIL pwm_duty b=%0d got %0d active cycles want %0d", b, active, want);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] mask [4];
    mask[0] = 16'h000F; mask[1] = 16'h00FF; mask[2] = 16'h0FFF; mask[3] = 16'hFFFF;
    for (int c = 0; c < 400; c++) begin
      bus.enable = ($urandom_range(0, 3) == 0);
      bus.digits = 16'($urandom) & mask[$urandom_range(0, 3)];
      bus.dp_in  = 4'($urandom);
      if (c % 16 == 0) bus.blank_lz = 1'($urandom);
      if (c % 8 == 0)  bus.brightness = 2'($urandom);
      step();
      checks++;
      if (bus.SSD !== exp_ssd || bus.SSD_sel !== exp_sel || bus.scan_tick !== exp_tick) begin
        failures++;
        $display("FAIL random n=%0d got SSD=%h sel=%h tick=%b want SSD=%h sel=%h tick=%b",
                 n, bus.SSD, bus.SSD_sel, bus.scan_tick, exp_ssd, exp_sel, exp_tick);
      end
    end
  endtask

  initial begin
    seg_tab[0]  = 8'hC0; seg_tab[1]  = 8'hF9; seg_tab[2]  = 8'hA4; seg_tab[3]  = 8'hB0;
    seg_tab[4]  = 8'h99; seg_tab[5]  = 8'h92; seg_tab[6]  = 8'h82; seg_tab[7]  = 8'hF8;
    seg_tab[8]  = 8'h80; seg_tab[9]  = 8'h90; seg_tab[10] = 8'h88; seg_tab[11] = 8'h83;
    seg_tab[12] = 8'hC6; seg_tab[13] = 8'hA1; seg_tab[14] = 8'h86; seg_tab[15] = 8'h8E;
    rst            = 1'b0;
    bus.enable     = 1'b0;
    bus.digits     = 16'h0000;
    bus.dp_in      = 4'h0;
    bus.blank_lz   = 1'b0;
    bus.brightness = 2'd3;
    model_reset();
    test_reset();
    test_scan_order();
    test_hold();
    test_leading_zero();
    test_dp();
    test_pwm();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
